// File: rtl/axis_packet_merger.sv
// axis_packet_merger: re-emits pckt_count back-to-back AXI-Stream packets as one merged packet.
// Define AXIS_MERGER_LEN_CHECK_EN to add the pckt_len port and per-packet length checking.
module axis_packet_merger #(
  parameter int DATA_WIDTH  = 16,
  parameter bit KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH  = KEEP_ENABLE ? (DATA_WIDTH + 7) / 8 : 1,
  parameter bit ID_ENABLE   = 0,
  parameter int ID_WIDTH    = ID_ENABLE ? 8 : 1,
  parameter bit DEST_ENABLE = 0,
  parameter int DEST_WIDTH  = DEST_ENABLE ? 8 : 1,
  parameter bit USER_ENABLE = 0,
  parameter int USER_WIDTH  = USER_ENABLE ? 8 : 1,
  parameter int PCKT_WIDTH  = 32,
  parameter bit ALLOW_LOCKS = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  operation_start,
  input  logic [PCKT_WIDTH-1:0] pckt_count,
`ifdef AXIS_MERGER_LEN_CHECK_EN
  input  logic [PCKT_WIDTH-1:0] pckt_len,
`endif
  input  logic                  lock,
  input  logic                  external_error,
  output logic                  operation_busy,
  output logic                  operation_complete,
  output logic                  operation_error,
  output logic                  transmission,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [ID_WIDTH-1:0]   s_axis_tid,
  input  logic [DEST_WIDTH-1:0] s_axis_tdest,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [ID_WIDTH-1:0]   m_axis_tid,
  output logic [DEST_WIDTH-1:0] m_axis_tdest,
  output logic [USER_WIDTH-1:0] m_axis_tuser
);

  localparam int PW = DATA_WIDTH + KEEP_WIDTH + ID_WIDTH + DEST_WIDTH + USER_WIDTH + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_OPE, ST_END, ST_ERR} state_t;

  state_t                state_q, state_d;
  logic [PCKT_WIDTH-1:0] target_q, cnt_q, target_m1;
  logic                  lock_active, s_hs, start_ope, len_err, out_last;
  logic                  out_valid_q, skid_valid_q;
  logic [PW-1:0]         in_pl, out_pl_q, skid_pl_q;

  assign lock_active   = ALLOW_LOCKS && lock;
  assign s_axis_tready = operation_busy && !skid_valid_q && !lock_active;
  assign s_hs          = s_axis_tvalid && s_axis_tready;
  assign target_m1     = target_q - PCKT_WIDTH'(1);
  assign out_last      = s_axis_tlast && (cnt_q == target_m1);
  assign start_ope     = (state_d == ST_OPE) && (state_q != ST_OPE);

  // Disabled sideband fields are tied off at the input so the buffer carries constants.
  assign in_pl = {s_axis_tdata,
                  KEEP_ENABLE ? s_axis_tkeep : {KEEP_WIDTH{1'b1}},
                  ID_ENABLE   ? s_axis_tid   : {ID_WIDTH{1'b0}},
                  DEST_ENABLE ? s_axis_tdest : {DEST_WIDTH{1'b0}},
                  USER_ENABLE ? s_axis_tuser : {USER_WIDTH{1'b0}},
                  out_last};
  assign {m_axis_tdata, m_axis_tkeep, m_axis_tid, m_axis_tdest, m_axis_tuser, m_axis_tlast} = out_pl_q;
  assign m_axis_tvalid = out_valid_q;

`ifdef AXIS_MERGER_LEN_CHECK_EN
  logic [PCKT_WIDTH-1:0] len_m1_q, beat_cnt_q;

  // A beat is in error when its tlast disagrees with being at index pckt_len-1.
  assign len_err = s_hs && (s_axis_tlast != (beat_cnt_q == len_m1_q));

  always_ff @(posedge clk) begin
    if (!rst) begin
      len_m1_q   <= '0;
      beat_cnt_q <= '0;
    end else if (start_ope) begin
      len_m1_q   <= pckt_len - PCKT_WIDTH'(1);
      beat_cnt_q <= '0;
    end else if (s_hs) begin
      beat_cnt_q <= s_axis_tlast ? '0 : beat_cnt_q + PCKT_WIDTH'(1);
    end
  end
`else
  assign len_err = 1'b0;
`endif

  // NOTE: every signal driven here gets a default first, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    if (external_error) begin
      state_d = ST_ERR;
    end else if (!lock_active) begin
      unique case (state_q)
        ST_IDLE, ST_END: begin
          if (operation_start)    state_d = (pckt_count != '0) ? ST_OPE : ST_ERR;
          else                    state_d = ST_IDLE;
        end
        ST_OPE: begin
          if (len_err)            state_d = ST_ERR;
          else if (s_hs && out_last) state_d = ST_END;
        end
        ST_ERR:                   state_d = ST_IDLE;
        default:                  state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q            <= ST_IDLE;
      target_q           <= '0;
      cnt_q              <= '0;
      operation_busy     <= 1'b0;
      operation_complete <= 1'b0;
      operation_error    <= 1'b0;
      transmission       <= 1'b0;
    end else begin
      state_q            <= state_d;
      operation_busy     <= (state_d == ST_OPE);
      operation_complete <= (state_d == ST_END) && (state_q != ST_END);
      operation_error    <= (state_d == ST_ERR);
      transmission       <= out_valid_q && m_axis_tready;
      if (start_ope) begin
        target_q <= pckt_count;
        cnt_q    <= '0;
      end else if (s_hs && s_axis_tlast) begin
        cnt_q    <= cnt_q + PCKT_WIDTH'(1);
      end
    end
  end

  // Skid buffer occupancy: the output register refills from the skid slot first.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (m_axis_tready || !out_valid_q) begin
      if (skid_valid_q) begin
        out_valid_q  <= 1'b1;
        skid_valid_q <= 1'b0;
      end else begin
        out_valid_q  <= s_hs;
      end
    end else if (s_hs) begin
      skid_valid_q <= 1'b1;
    end
  end

  // NOTE: payload registers carry no reset; the valid flags alone qualify their contents.
  always_ff @(posedge clk) begin
    if (m_axis_tready || !out_valid_q) begin
      if (skid_valid_q) out_pl_q <= skid_pl_q;
      else if (s_hs)    out_pl_q <= in_pl;
    end else if (s_hs) begin
      skid_pl_q <= in_pl;
    end
  end

endmodule

// File: doc/axis_packet_merger.md
Name: axis_packet_merger

Overview:
- Downstream companion of the packet splitter. Consumes a stream of N back-to-back AXI-Stream packets and re-emits them as one merged packet.
- Every input tlast except the Nth is suppressed; the Nth input tlast becomes the single output tlast.
- Uses the same operation_start / busy / complete / error control handshake as the other stream control stages, so both blocks can be driven by one sequencer.

Parameters:
- DATA_WIDTH, 16, tdata width in bits
- KEEP_ENABLE, (DATA_WIDTH>8), propagate tkeep
- KEEP_WIDTH, KEEP_ENABLE ? (DATA_WIDTH+7)/8 : 1, tkeep width
- ID_ENABLE, 0, propagate tid; ID_WIDTH, ID_ENABLE ? 8 : 1
- DEST_ENABLE, 0, propagate tdest; DEST_WIDTH, DEST_ENABLE ? 8 : 1
- USER_ENABLE, 0, propagate tuser; USER_WIDTH, USER_ENABLE ? 8 : 1
- PCKT_WIDTH, 32, width of the packet-count operand and internal counter
- ALLOW_LOCKS, 1, when 1 the lock input is honoured; when 0 lock is ignored

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-low reset
- operation_start  in  1  begin a merge operation (sampled in IDLE/END)
- pckt_count  in  PCKT_WIDTH  number of input packets to merge; latched on start
- lock  in  1  freeze state and stall input
- external_error  in  1  force error
- operation_busy  out  1  registered; high while in OPE
- operation_complete  out  1  registered; one-cycle pulse on completion
- operation_error  out  1  registered; one-cycle pulse in ERR
- transmission  out  1  registered; high the cycle after an m_axis handshake
- s_axis_tdata/tkeep/tvalid/tready/tlast/tid/tdest/tuser  in (tready out)  per parameters  input stream
- m_axis_tdata/tkeep/tvalid/tready/tlast/tid/tdest/tuser  out (tready in)  per parameters  output stream

Behaviour:
- Reset (rst=0 at clk edge):
  - FSM goes to IDLE; packet counter cleared.
  - Output skid buffer emptied: m_axis_tvalid=0.
  - operation_busy, operation_complete, operation_error and transmission are all 0.
  - Reset mid-operation discards any buffered beat.
- FSM states: IDLE, OPE, END, ERR.
  - IDLE: start=1 with pckt_count!=0 -> OPE. start=1 with pckt_count==0 -> ERR. Otherwise stay in IDLE.
  - OPE: stay until an accepted input beat has tlast=1 and cnt==target-1; then -> END.
  - END: same rules as IDLE (allows back-to-back operations).
  - ERR: -> IDLE after one cycle.
  - external_error=1 in any state -> ERR next cycle. This has priority over start, completion and lock.
- Flag timing:
  - operation_busy, operation_complete and operation_error are driven from the next state, so each is valid in the same cycle the FSM occupies OPE/END/ERR.
  - operation_complete is high for exactly one cycle per END visit.
- Counter and output tlast:
  - target is latched on the IDLE/END->OPE transition; cnt is cleared on entry to OPE.
  - cnt increments on each accepted input beat with tlast=1.
  - Output tlast = input tlast AND (cnt==target-1). All other tlasts are forwarded as 0.
  - Comparison uses target-1 computed at PCKT_WIDTH bits; target=2^PCKT_WIDTH-1 is legal; no wrap occurs because completion precedes overflow.
- Handshake:
  - Input handshake: s_axis_tready = operation_busy AND skid-buffer ready AND not (ALLOW_LOCKS && lock). The stage never accepts a beat outside OPE.
  - Data path: 2-entry skid buffer. Latency is 1 cycle from input acceptance to m_axis_tvalid. Full throughput (1 beat/cycle) with m_axis_tready held high.
  - m_axis_tvalid stays high, with payload stable, until m_axis_tready is asserted.
  - Beats accepted before END are still drained after END or ERR. ERR does not flush the buffer; only reset does.
- Lock (ALLOW_LOCKS=1, lock=1): FSM transitions are frozen, except external_error; input is stalled; the output buffer continues to drain.
- Simultaneous events:
  - Completing beat with external_error in the same cycle -> ERR. The beat is forwarded but no complete pulse is raised.
  - operation_start while in OPE is ignored.

Optional Feature:
- Macro: AXIS_MERGER_LEN_CHECK_EN
- When defined:
  - Adds input port pckt_len [PCKT_WIDTH-1:0], latched with pckt_count.
  - Adds a beat counter per input packet.
  - An input tlast arriving at beat index != pckt_len-1, or a beat index reaching pckt_len without tlast, sends the FSM to ERR. The offending beat is still forwarded.
- When undefined: no pckt_len port; packet lengths are unchecked.

Test Plan:
- Merge: pckt_count=3, three 4-beat packets, m_tready=1 -> 12 output beats; m_tlast only on beat 12; complete pulses once, 1 cycle after the last acceptance; transmission high for 12 cycles.
- Backpressure: pckt_count=2, m_tready toggling 1/0 every cycle -> data order preserved, no beat lost or duplicated, s_tready drops whenever the skid buffer is full.
- Zero count: start with pckt_count=0 -> error pulses for 1 cycle, FSM returns to IDLE, s_tready stays 0.
- Lock and error: lock=1 mid-packet for 5 cycles -> s_tready=0 and busy held. Then external_error=1 -> error pulse, no complete pulse, buffered beat still drained.
- Reset mid-operation: rst=0 after 2 of 3 packets -> next cycle m_tvalid=0 and all flags 0. A new start with pckt_count=1 merges correctly.
- With AXIS_MERGER_LEN_CHECK_EN: pckt_len=4 and a 3-beat packet -> error pulse on the cycle after the short tlast is accepted.
